controlador_matricial: RTL and testbench
========================================

Name: controlador_matricial

Overview:
- Sequencer for the 5x5 int8 matrix ALU.
- Accepts one command at a time from the HPS-side instruction bus and fetches matrices A and B row-by-row from on-chip matrix memory.
- Drives the ALU start/done handshake, then writes the 200-bit result back to memory.
- Sits between the instruction decoder/PIO bridge and the ALU + matrix RAM.

Parameters:
- ROWS, 5, matrix rows per operand; row width = 40 bits (5 x int8).
- ADDR_W, 8, matrix-memory address width (row-addressed).
- TIMEOUT, 64, max cycles waiting for alu_done before error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- instr  in  28  {opcode[27:24], base_a[23:16], base_b[15:8], base_r[7:0]}.
- instr_valid  in  1  command present.
- instr_ready  out  1  controller can accept.
- cmd_done  out  1  one-cycle pulse when a command finishes.
- cmd_error  out  1  sticky error flag; cleared on next accepted command.
- busy  out  1  high whenever state != IDLE.
- mem_addr  out  ADDR_W  row address.
- mem_rd  out  1  read strobe; read data valid next cycle.
- mem_rdata  in  40  read row data.
- mem_wr  out  1  write strobe.
- mem_wdata  out  40  write row data.
- alu_opcode  out  4  opcode to ALU.
- alu_matrizA  out  200  operand A (row k at [40k+39:40k]).
- alu_matrizB  out  200  operand B, same layout.
- alu_start  out  1  ALU start level.
- alu_resultado  in  200  ALU result.
- alu_done  in  1  ALU done level.

Behaviour:
- Reset (async, rst_n=0) values:
  - State IDLE; instr_ready=1.
  - busy, cmd_done, cmd_error, mem_rd, mem_wr, alu_start = 0.
  - Address, data and opcode registers = 0.
  - Reset mid-operation aborts immediately; no further memory writes occur.
- Accept rule:
  - A command is taken when instr_valid & instr_ready at a clk edge.
  - The opcode and all three bases are latched at that edge.
  - instr_ready=0 in every state except IDLE; instr_valid is ignored while busy.
- Legal opcodes are 0011 (soma), 0100 (subtracao), 0101 (multiplicacao), 0110 (transposta) and 0111 (oposta).
- Illegal opcode:
  - Go to FINISH with cmd_error=1.
  - No mem_rd, mem_wr or alu_start activity.
- States:
  - IDLE → FETCH_A → FETCH_B → EXEC → RELEASE → STORE → FINISH → IDLE.
- FETCH_A (6 cycles):
  - Row counter k=0..5.
  - While k<5: mem_rd=1, mem_addr=(base_a+k) mod 2^ADDR_W; wrap-around is legal.
  - While k>=1: capture mem_rdata into alu_matrizA row k-1.
  - At k=5 go to FETCH_B.
- FETCH_B: identical to FETCH_A using base_b, filling alu_matrizB.
- EXEC:
  - alu_start=1, held continuously; alu_opcode is stable for the whole command.
  - Each cycle in EXEC, if alu_done=1: latch alu_resultado, go to RELEASE.
  - Otherwise increment the wait counter.
  - When the counter reaches TIMEOUT: cmd_error=1, go to FINISH with no store.
- RELEASE (1 cycle): alu_start=0, which lets the ALU clear done.
- STORE (5 cycles):
  - mem_wr=1, mem_addr=(base_r+k) mod 2^ADDR_W.
  - mem_wdata = result row k, k=0..4.
- FINISH (1 cycle): cmd_done=1, then IDLE with instr_ready=1.
- Latency:
  - For an accept at edge T and an ALU that asserts done one cycle after start, cmd_done is high during cycle T+21.
  - A slower ALU adds its extra cycles one-for-one.
- alu_done already high on EXEC entry (stale) counts as done; RELEASE guarantees this cannot happen between commands.
- Overlapping regions (base_r overlapping base_a or base_b) are allowed, since operands are fully fetched before any write.

Decomposition:
- Shared package matriz_pkg:
  - Opcode localparams (OP_SOMA=4'b0011 … OP_OPOSTA=4'b0111).
  - Row/element width constants (ELEM_W=8, ROW_W=40, MAT_W=200).
  - State enum encoding.
- One natural sub-module, contador_linhas: the row counter with wrap-aware address adder, shared by FETCH_A, FETCH_B and STORE.

Test Plan:
- Soma, 1-cycle ALU model:
  - Stimulus: A rows at 0x10..0x14 all 0x01, B rows at 0x20..0x24 all 0x02, base_r=0x30, accept at T.
  - Required: 5 reads per operand in order, writes to 0x30..0x34 with data 0x0303030303, cmd_done pulse at T+21, cmd_error=0.
- Address wrap:
  - Stimulus: base_a=0xFD.
  - Required: reads at 0xFD, 0xFE, 0xFF, 0x00, 0x01, with rows placed 0..4 in alu_matrizA.
- Slow ALU:
  - Stimulus: alu_done raised 10 cycles after alu_start.
  - Required: alu_start stays high until done is seen, drops for exactly 1 cycle, cmd_done at T+30.
- Timeout:
  - Stimulus: alu_done never asserted.
  - Required: after 64 EXEC cycles, cmd_error=1 and cmd_done pulse, zero mem_wr strobes.
- Illegal opcode 1111:
  - Required: cmd_done and cmd_error on the cycle after accept, no memory or ALU activity.
  - A following legal command clears cmd_error.
- Reset mid-STORE:
  - Stimulus: rst_n low during the 3rd write.
  - Required: mem_wr=0 immediately, busy=0, instr_ready=1.
  - instr_valid held during busy before the reset must not have been accepted.

Source files
------------

// File: rtl/controlador_matricial_pkg.sv
// Purpose: shared constants, opcodes and FSM encoding for the matrix sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matriz_pkg;

  localparam int ELEM_W   = 8;
  localparam int ROWS_DEF = 5;
  localparam int ROW_W    = ROWS_DEF * ELEM_W;  // 40
  localparam int MAT_W    = ROWS_DEF * ROW_W;   // 200
  localparam int INSTR_W  = 28;
  localparam int OPC_W    = 4;

  localparam logic [OPC_W-1:0] OP_SOMA          = 4'b0011;
  localparam logic [OPC_W-1:0] OP_SUBTRACAO     = 4'b0100;
  localparam logic [OPC_W-1:0] OP_MULTIPLICACAO = 4'b0101;
  localparam logic [OPC_W-1:0] OP_TRANSPOSTA    = 4'b0110;
  localparam logic [OPC_W-1:0] OP_OPOSTA        = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_A,
    ST_FETCH_B,
    ST_EXEC,
    ST_RELEASE,
    ST_STORE,
    ST_FINISH
  } state_t;

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    return op inside {OP_SOMA, OP_SUBTRACAO, OP_MULTIPLICACAO, OP_TRANSPOSTA, OP_OPOSTA};
  endfunction

endpackage

// File: rtl/controlador_matricial_if.sv
// Purpose: bundles instruction bus, matrix-memory port and ALU handshake of the sequencer.
// Latency: n/a (wiring only). master = sequencer side, slave = environment side.
// Backpressure: instr_valid/instr_ready on the command side; memory and ALU are never stalled.
interface controlador_matricial_if
  import matriz_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int ROWS   = ROWS_DEF
) ();

  localparam int LW = ROWS * ELEM_W;
  localparam int MW = ROWS * LW;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               cmd_done;
  logic               cmd_error;
  logic               busy;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic [LW-1:0]      mem_rdata;
  logic               mem_wr;
  logic [LW-1:0]      mem_wdata;
  logic [OPC_W-1:0]   alu_opcode;
  logic [MW-1:0]      alu_matrizA;
  logic [MW-1:0]      alu_matrizB;
  logic               alu_start;
  logic [MW-1:0]      alu_resultado;
  logic               alu_done;

  modport master (
    input  instr, instr_valid, mem_rdata, alu_resultado, alu_done,
    output instr_ready, cmd_done, cmd_error, busy, mem_addr, mem_rd, mem_wr, mem_wdata,
           alu_opcode, alu_matrizA, alu_matrizB, alu_start
  );

  modport slave (
    output instr, instr_valid, mem_rdata, alu_resultado, alu_done,
    input  instr_ready, cmd_done, cmd_error, busy, mem_addr, mem_rd, mem_wr, mem_wdata,
           alu_opcode, alu_matrizA, alu_matrizB, alu_start
  );

endinterface

// File: rtl/controlador_matricial_contador_linhas.sv
// Purpose: row counter k with wrap-around row address addr = (base + k) mod 2^ADDR_W.
// Latency: k changes one cycle after clr/inc; addr is combinational from k and base.
// Backpressure: none; the sequencer decides when to clear or advance.
// Ports: clk, rst_n, clr (k<=0, wins over inc), inc (k<=k+1), base, k, addr.
module contador_linhas #(
  parameter int ADDR_W = 8,
  parameter int KW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base,
  output logic [KW-1:0]     k,
  output logic [ADDR_W-1:0] addr
);

  logic [KW-1:0] k_q, k_d;

  always_comb begin
    k_d = k_q;
    if (clr) begin
      k_d = '0;
    end else if (inc) begin
      k_d = k_q + KW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign k = k_q;
  // Truncation to ADDR_W bits gives the legal wrap past the top of memory.
  assign addr = base + ADDR_W'(k_q);

endmodule

// File: rtl/controlador_matricial.sv
// Purpose: sequences one matrix-ALU command: fetch A and B rows, run ALU, store result rows.
// Latency: accept->cmd_done = 21 cycles with a 1-cycle ALU, plus extra ALU cycles one-for-one.
// Backpressure: instr_ready only in IDLE; memory and ALU are assumed always ready.
// Ports: clk, rst_n (async, active-low), bus (controlador_matricial_if.master).
module controlador_matricial
  import matriz_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int ROWS    = ROWS_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  controlador_matricial_if.master bus
);

  localparam int LW = ROWS * ELEM_W;
  localparam int KW = $clog2(ROWS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [KW-1:0] K_FETCH_END = KW'(ROWS);
  localparam logic [KW-1:0] K_STORE_END = KW'(ROWS - 1);
  localparam logic [TW-1:0] WAIT_LAST   = TW'(TIMEOUT - 1);

  state_t                    state_q, state_d;
  logic [OPC_W-1:0]          opcode_q, opcode_d;
  logic [ADDR_W-1:0]         base_a_q, base_a_d;
  logic [ADDR_W-1:0]         base_b_q, base_b_d;
  logic [ADDR_W-1:0]         base_r_q, base_r_d;
  logic                      cmd_error_q, cmd_error_d;
  logic [TW-1:0]             wait_q, wait_d;
  logic [ROWS-1:0][LW-1:0]   mat_a_q, mat_a_d;
  logic [ROWS-1:0][LW-1:0]   mat_b_q, mat_b_d;
  logic [ROWS-1:0][LW-1:0]   res_q, res_d;

  logic                      cnt_clr, cnt_inc;
  logic [ADDR_W-1:0]         cnt_base, cnt_addr;
  logic [KW-1:0]             cnt_k, row_prev;
  logic                      new_legal;

  contador_linhas #(.ADDR_W(ADDR_W), .KW(KW)) u_contador_linhas (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .base (cnt_base),
    .k    (cnt_k),
    .addr (cnt_addr)
  );

  // Read data lags the strobe by one cycle, so at count k we hold row k-1.
  assign row_prev  = cnt_k - KW'(1);
  assign new_legal = op_legal(bus.instr[27:24]);

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    base_a_d    = base_a_q;
    base_b_d    = base_b_q;
    base_r_d    = base_r_q;
    cmd_error_d = cmd_error_q;
    wait_d      = wait_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;
    res_d       = res_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    cnt_base    = base_a_q;

    bus.instr_ready = 1'b0;
    bus.cmd_done    = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.alu_start   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          opcode_d    = bus.instr[27:24];
          base_a_d    = bus.instr[23:16];
          base_b_d    = bus.instr[15:8];
          base_r_d    = bus.instr[7:0];
          cmd_error_d = !new_legal;
          wait_d      = '0;
          cnt_clr     = 1'b1;
          state_d     = new_legal ? ST_FETCH_A : ST_FINISH;
        end
      end

      ST_FETCH_A, ST_FETCH_B: begin
        cnt_base = (state_q == ST_FETCH_A) ? base_a_q : base_b_q;
        if (cnt_k != K_FETCH_END) begin
          bus.mem_rd   = 1'b1;
          bus.mem_addr = cnt_addr;
        end
        if (cnt_k != '0) begin
          if (state_q == ST_FETCH_A) begin
            mat_a_d[row_prev] = bus.mem_rdata;
          end else begin
            mat_b_d[row_prev] = bus.mem_rdata;
          end
        end
        if (cnt_k == K_FETCH_END) begin
          cnt_clr = 1'b1;
          state_d = (state_q == ST_FETCH_A) ? ST_FETCH_B : ST_EXEC;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      ST_EXEC: begin
        // A done level already present on entry is taken as completion.
        bus.alu_start = 1'b1;
        if (bus.alu_done) begin
          res_d   = bus.alu_resultado;
          state_d = ST_RELEASE;
        end else if (wait_q == WAIT_LAST) begin
          cmd_error_d = 1'b1;
          state_d     = ST_FINISH;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end

      ST_RELEASE: begin
        // One cycle with start low so the ALU drops done before the next command.
        cnt_clr = 1'b1;
        state_d = ST_STORE;
      end

      ST_STORE: begin
        cnt_base      = base_r_q;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = cnt_addr;
        bus.mem_wdata = res_q[cnt_k];
        if (cnt_k == K_STORE_END) begin
          cnt_clr = 1'b1;
          state_d = ST_FINISH;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      ST_FINISH: begin
        bus.cmd_done = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      base_r_q    <= '0;
      cmd_error_q <= 1'b0;
      wait_q      <= '0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      base_a_q    <= base_a_d;
      base_b_q    <= base_b_d;
      base_r_q    <= base_r_d;
      cmd_error_q <= cmd_error_d;
      wait_q      <= wait_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
      res_q       <= res_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.cmd_error   = cmd_error_q;
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_matrizA = mat_a_q;
  assign bus.alu_matrizB = mat_b_q;

endmodule

// File: tb/tb_controlador_matricial.sv
// Purpose: scoreboard bench for controlador_matricial with a row memory and a byte-wise ALU model.
// Latency: cycle offsets are counted with the cycle right after the accept edge as T+1.
// Backpressure: commands are issued only while instr_ready is high.
module tb_controlador_matricial;
  import matriz_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  controlador_matricial_if #(.ADDR_W(8), .ROWS(5)) bus ();

  controlador_matricial #(.ADDR_W(8), .ROWS(5), .TIMEOUT(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct { logic [7:0] addr; logic [39:0] data; int off; } mem_ev_t;
  typedef struct { int off; logic err; } done_ev_t;

  mem_ev_t  rd_q[$];
  mem_ev_t  wr_q[$];
  done_ev_t done_q[$];
  int       start_q[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int t_acc = 0;
  int start_run = 0;
  int alu_lat = 1;
  int alu_cnt = 0;
  logic alu_done_r = 1'b0;
  logic err_at_accept = 1'b0;
  logic [39:0] mem [256];
  logic [199:0] alu_res;

  task automatic chk_w(input string name, input logic [199:0] act, input logic [199:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got no matching event, expected one", name);
  endtask

  // ---------------- environment models ----------------
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
  end

  always @(posedge clk) begin
    if (!bus.alu_start) begin
      alu_cnt    <= 0;
      alu_done_r <= 1'b0;
    end else begin
      alu_cnt <= alu_cnt + 1;
      if (alu_lat != 0 && alu_cnt + 1 >= alu_lat) alu_done_r <= 1'b1;
    end
  end
  assign bus.alu_done = alu_done_r;

  always_comb begin
    alu_res = '0;
    for (int i = 0; i < 25; i++) begin
      if (bus.alu_opcode == OP_SUBTRACAO)
        alu_res[i*8 +: 8] = bus.alu_matrizA[i*8 +: 8] - bus.alu_matrizB[i*8 +: 8];
      else
        alu_res[i*8 +: 8] = bus.alu_matrizA[i*8 +: 8] + bus.alu_matrizB[i*8 +: 8];
    end
  end
  assign bus.alu_resultado = alu_res;

  // ---------------- monitor ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      int off;
      mem_ev_t ev;
      done_ev_t de;
      off = cyc - t_acc + 1;
      if (bus.mem_rd) begin
        if (rd_q.size() == 0) miss("rd_unexpected");
        else begin
          ev = rd_q.pop_front();
          chk_w("rd_addr", 200'(bus.mem_addr), 200'(ev.addr));
          chk_i("rd_cycle", off, ev.off);
        end
      end
      if (bus.mem_wr) begin
        if (wr_q.size() == 0) miss("wr_unexpected");
        else begin
          ev = wr_q.pop_front();
          chk_w("wr_addr", 200'(bus.mem_addr), 200'(ev.addr));
          chk_w("wr_data", 200'(bus.mem_wdata), 200'(ev.data));
          chk_i("wr_cycle", off, ev.off);
        end
      end
      if (bus.cmd_done) begin
        if (done_q.size() == 0) miss("done_unexpected");
        else begin
          de = done_q.pop_front();
          chk_i("done_cycle", off, de.off);
          chk_i("done_error", int'(bus.cmd_error), int'(de.err));
        end
      end
      if (bus.alu_start) start_run++;
      else if (start_run != 0) begin
        if (start_q.size() == 0) miss("start_unexpected");
        else chk_i("start_len", start_run, start_q.pop_front());
        start_run = 0;
      end
      if (bus.instr_valid && bus.instr_ready) t_acc = cyc + 1;
    end
  end

  // ---------------- expectation helpers ----------------
  task automatic exp_reads(input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < 5; k++) rd_q.push_back('{addr: 8'(a + k), data: 40'h0, off: 1 + k});
    for (int k = 0; k < 5; k++) rd_q.push_back('{addr: 8'(b + k), data: 40'h0, off: 7 + k});
  endtask

  task automatic exp_writes(input logic [7:0] r, input int lat, input logic [199:0] res, input int n);
    for (int k = 0; k < n; k++)
      wr_q.push_back('{addr: 8'(r + k), data: res[k*40 +: 40], off: 15 + lat + k});
  endtask

  task automatic exp_done(input int off, input logic err);
    done_q.push_back('{off: off, err: err});
  endtask

  task automatic run_cmd(input logic [27:0] ins, input int lat);
    int n;
    alu_lat = lat;
    n = 0;
    while (!bus.instr_ready && n < 100) begin @(posedge clk); #1; n++; end
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    err_at_accept = bus.cmd_error;
    n = 0;
    while (!bus.cmd_done && n < 200) begin @(posedge clk); #1; n++; end
    if (!bus.cmd_done) miss("cmd_done_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, expected summary");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] idx;
    int n;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 40'h0;
    for (int i = 0; i < 5; i++) begin
      idx = 8'(8'h10 + i); mem[idx] = 40'h0101010101;
      idx = 8'(8'h20 + i); mem[idx] = 40'h0202020202;
      idx = 8'(8'hFD + i); mem[idx] = 40'(i + 1);
    end

    #1 rst_n = 1'b0;
    #3;
    chk_i("rst_instr_ready", int'(bus.instr_ready), 1);
    chk_i("rst_busy", int'(bus.busy), 0);
    chk_i("rst_cmd_done", int'(bus.cmd_done), 0);
    chk_i("rst_cmd_error", int'(bus.cmd_error), 0);
    chk_i("rst_mem_rd", int'(bus.mem_rd), 0);
    chk_i("rst_mem_wr", int'(bus.mem_wr), 0);
    chk_i("rst_alu_start", int'(bus.alu_start), 0);
    chk_w("rst_alu_opcode", 200'(bus.alu_opcode), 200'h0);
    chk_w("rst_mem_addr", 200'(bus.mem_addr), 200'h0);
    chk_w("rst_matA", bus.alu_matrizA, 200'h0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // soma with 1-cycle ALU
    exp_reads(8'h10, 8'h20);
    exp_writes(8'h30, 1, {5{40'h0303030303}}, 5);
    exp_done(21, 1'b0);
    start_q.push_back(2);
    run_cmd({OP_SOMA, 8'h10, 8'h20, 8'h30}, 1);

    // address wrap on A, subtracao
    exp_reads(8'hFD, 8'h20);
    exp_writes(8'h40, 1, {40'hFEFEFEFE03, 40'hFEFEFEFE02, 40'hFEFEFEFE01,
                          40'hFEFEFEFE00, 40'hFEFEFEFEFF}, 5);
    exp_done(21, 1'b0);
    start_q.push_back(2);
    run_cmd({OP_SUBTRACAO, 8'hFD, 8'h20, 8'h40}, 1);
    chk_w("wrap_matA", bus.alu_matrizA,
          {40'h0000000005, 40'h0000000004, 40'h0000000003, 40'h0000000002, 40'h0000000001});

    // slow ALU: done 10 cycles after start
    exp_reads(8'h10, 8'h20);
    exp_writes(8'h38, 10, {5{40'h0303030303}}, 5);
    exp_done(30, 1'b0);
    start_q.push_back(11);
    run_cmd({OP_SOMA, 8'h10, 8'h20, 8'h38}, 10);

    // timeout: done never comes
    exp_reads(8'h10, 8'h20);
    exp_done(77, 1'b1);
    start_q.push_back(64);
    run_cmd({OP_MULTIPLICACAO, 8'h10, 8'h20, 8'h60}, 0);
    chk_i("timeout_error_sticky", int'(bus.cmd_error), 1);

    // illegal opcode, then a legal one clears the error
    exp_done(1, 1'b1);
    run_cmd({4'b1111, 8'h10, 8'h20, 8'h30}, 1);
    chk_i("illegal_error_sticky", int'(bus.cmd_error), 1);
    exp_reads(8'h10, 8'h20);
    exp_writes(8'h30, 1, {5{40'h0303030303}}, 5);
    exp_done(21, 1'b0);
    start_q.push_back(2);
    run_cmd({OP_SOMA, 8'h10, 8'h20, 8'h30}, 1);
    chk_i("error_cleared_on_accept", int'(err_at_accept), 0);

    // reset during the third store write, with a second command held meanwhile
    exp_reads(8'h10, 8'h20);
    exp_writes(8'h70, 1, {5{40'h0303030303}}, 2);
    start_q.push_back(2);
    alu_lat = 1;
    bus.instr = {OP_SOMA, 8'h10, 8'h20, 8'h70};
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr = {OP_SOMA, 8'h50, 8'h51, 8'h52};
    n = 0;
    while (!bus.mem_wr && n < 100) begin @(posedge clk); #1; n++; end
    if (!bus.mem_wr) miss("store_start_timeout");
    repeat (2) begin @(posedge clk); #1; end
    chk_i("third_write_active", int'(bus.mem_wr), 1);
    chk_w("third_write_addr", 200'(bus.mem_addr), 200'h72);
    #2 rst_n = 1'b0;
    #1;
    chk_i("rst_mid_mem_wr", int'(bus.mem_wr), 0);
    chk_i("rst_mid_busy", int'(bus.busy), 0);
    chk_i("rst_mid_instr_ready", int'(bus.instr_ready), 1);
    chk_i("rst_mid_alu_start", int'(bus.alu_start), 0);
    bus.instr_valid = 1'b0;
    #10 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_i("idle_after_reset", int'(bus.busy), 0);

    chk_i("rd_left", rd_q.size(), 0);
    chk_i("wr_left", wr_q.size(), 0);
    chk_i("done_left", done_q.size(), 0);
    chk_i("start_left", start_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
